inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction-fetch stage of the venus pipeline; it is the producer side of the decode stage's instruction input.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents inst_o / inst_valid_o / pc_o to ID and honours ID's stall_o, fed back as stall_i.
- Accepts branch redirects from execute, flushes the wrong-path instruction and refetches from the target.

Parameters:
- ADDR_W, 32, PC and imem address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  ID stall_o; hold current instruction.
- br_taken_i  in  1  redirect request from EX.
- br_target_i  in  ADDR_W  redirect target (byte address).
- imem_req_o  out  1  read request; held until ack.
- imem_addr_o  out  ADDR_W  read address; stable while req=1 and no ack.
- imem_ack_i  in  1  read data valid this cycle.
- imem_data_i  in  32  instruction word {opecode[31:25], immf[24], rd[23:20], rs[19:16], imm[15:0]}.
- inst_o  out  32  instruction to ID; NOP (32'h0) when invalid.
- inst_valid_o  out  1  inst_o carries a real instruction.
- pc_o  out  ADDR_W  address of inst_o.

Behaviour:
- Reset values:
  - pc=RESET_PC; state=IDLE.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - inst_o=32'h0, inst_valid_o=0, pc_o=0.
  - Hold buffer empty; discard flag=0.
- Reset deasserted mid-access: any in-flight ack is ignored; the first access after reset is always RESET_PC.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: always moves to REQ next cycle. imem_req_o=1, imem_addr_o=pc.
- REQ:
  - req held; addr is pc.
  - On ack with stall_i=0: register inst_o<=imem_data_i, inst_valid_o<=1, pc_o<=pc, pc<=pc+4; stay in REQ with the new address next cycle.
  - Throughput is 1 inst/cycle when imem acks every cycle.
  - If imem_ack_i=0 while stall_i=0: inst_valid_o<=0, inst_o<=NOP.
- Stall:
  - While stall_i=1, inst_o/inst_valid_o/pc_o are frozen.
  - Ack during stall: data and its PC go to the 1-entry hold buffer, pc<=pc+4, imem_req_o drops next cycle, go to HOLD.
  - HOLD: wait for stall_i=0, then buffer moves to outputs next cycle (valid=1), buffer cleared, return to REQ.
  - No ack during stall: remain in REQ with req held.
- Redirect (br_taken_i=1) has top priority, including over stall:
  - pc<=br_target_i with bits[1:0] forced 0.
  - inst_valid_o<=0, inst_o<=NOP, hold buffer cleared.
  - Request outstanding with no ack this cycle: go to DRAIN, keep req/addr stable until ack, discard that data, then REQ at the target.
  - Ack in the same cycle as redirect: data discarded; next cycle REQ at the target.
  - Redirect while in DRAIN: update the target; stay in DRAIN.
- PC arithmetic is mod 2^ADDR_W; pc+4 from all-ones-minus-3 wraps to 0.
- Invariants:
  - At most one outstanding imem request.
  - imem_addr_o never changes while req=1 and ack=0.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] (count of instructions delivered with valid=1, flushed ones excluded) and stall_cnt_o[31:0] (cycles with stall_i=1).
- Both counters are reset to 0 and wrap.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package venus_pkg holds:
  - Instruction field bit positions (OPC_MSB/LSB, IMMF_BIT, RD, RS, IMM ranges).
  - NOP_INST=32'h0.
  - PC_STEP=4.
  - FSM state encodings.
- Sub-module if_hold_buf: 1-entry inst+PC buffer with load/clear/valid. The top level keeps the FSM and PC.

Test Plan:
- Reset then imem acks every cycle with data 32'h0200_0001, 32'h0400_0002 -> imem_addr_o 0x0,0x4,0x8; inst_o matches with 1-cycle latency; pc_o=0x0,0x4; valid=1 continuously.
- Assert stall_i for 3 cycles after inst at pc 0x4, while imem acks pc 0x8 -> outputs frozen at pc 0x4; req drops; after release pc_o=0x8 with buffered word; fetch resumes at 0xC.
- Redirect br_target_i=0x103 with no outstanding ack -> next valid inst has pc_o=0x100; the following imem_addr_o is 0x104.
- Redirect while req outstanding; ack 2 cycles later with 32'hDEAD_BEEF -> that word never appears valid; addr stable through DRAIN; next request addr=target.
- Redirect and stall simultaneous -> valid=0 next cycle; hold buffer cleared; fetch from target regardless of stall_i.
- pc reaches 32'hFFFF_FFFC with ack -> next imem_addr_o=0x0. With IF_PERF_CNT_EN: fetch_cnt_o equals the count of valid deliveries, and stall_cnt_o=3 after the stall scenario.

Source files
------------

// File: rtl/venus_pkg.sv
// Shared definitions for the venus pipeline: instruction field layout, fetch constants
// and the instruction-fetch FSM state encoding.
package venus_pkg;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 25;
    localparam int unsigned IMMF_BIT = 24;
    localparam int unsigned RD_MSB   = 23;
    localparam int unsigned RD_LSB   = 20;
    localparam int unsigned RS_MSB   = 19;
    localparam int unsigned RS_LSB   = 16;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_LSB  = 0;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StHold  = 2'd2,
        StDrain = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction + PC buffer that catches a word fetched while decode is stalled.
// Clear takes priority over load.
module if_hold_buf
    import venus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// venus instruction-fetch stage: owns the PC, drives the imem req/ack port and feeds decode.
// Define IF_PERF_CNT_EN to add the fetch_cnt_o / stall_cnt_o performance counters.
module inst_fetch
    import venus_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] pc_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    if_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       inst_q;
    logic              valid_q;
    logic [ADDR_W-1:0] pc_out_q;

    logic              buf_load;
    logic              buf_clear;
    logic              buf_valid;
    logic [31:0]       buf_inst;
    logic [ADDR_W-1:0] buf_pc;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_tgt;

    assign pc_inc = pc_q + ADDR_W'(PC_STEP);
    assign br_tgt = {br_target_i[ADDR_W-1:2], 2'b00};

    // Buffer catches a word acked while decode is stalled; a redirect or release empties it.
    assign buf_load  = !br_taken_i && (state_q == StReq) && imem_ack_i && stall_i;
    assign buf_clear = br_taken_i || ((state_q == StHold) && !stall_i);

    if_hold_buf #(
        .ADDR_W(ADDR_W)
    ) u_hold_buf (
        .clk    (clk),
        .rst    (rst),
        .load_i (buf_load),
        .clear_i(buf_clear),
        .inst_i (imem_data_i),
        .pc_i   (pc_q),
        .valid_o(buf_valid),
        .inst_o (buf_inst),
        .pc_o   (buf_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            inst_q   <= NOP_INST;
            valid_q  <= 1'b0;
            pc_out_q <= '0;
        end else if (br_taken_i) begin
            pc_q    <= br_tgt;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            // An unanswered request must complete before the target can be issued.
            if (req_q && !imem_ack_i) begin
                state_q <= StDrain;
            end else begin
                state_q <= StReq;
                req_q   <= 1'b1;
                addr_q  <= br_tgt;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                StReq: begin
                    if (imem_ack_i) begin
                        pc_q <= pc_inc;
                        if (stall_i) begin
                            req_q   <= 1'b0;
                            state_q <= StHold;
                        end else begin
                            inst_q   <= imem_data_i;
                            valid_q  <= 1'b1;
                            pc_out_q <= pc_q;
                            addr_q   <= pc_inc;
                        end
                    end else if (!stall_i) begin
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (!stall_i) begin
                        inst_q   <= buf_inst;
                        valid_q  <= buf_valid;
                        pc_out_q <= buf_pc;
                        req_q    <= 1'b1;
                        addr_q   <= pc_q;
                        state_q  <= StReq;
                    end
                end
                StDrain: begin
                    if (imem_ack_i) begin
                        state_q <= StReq;
                        addr_q  <= pc_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign pc_o         = pc_out_q;

`ifdef IF_PERF_CNT_EN
    logic        deliver;
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    assign deliver = !br_taken_i && !stall_i &&
                     (((state_q == StReq) && imem_ack_i) || ((state_q == StHold) && buf_valid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (deliver) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
